// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// uart_rx_deserializer : 1-sample-per-bit UART receiver, one-word read buffer
// Rev 1.0
// ============================================================================
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 32,
    parameter int PARITY_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Rx_Enable,
    input  logic                  Rx_Serial_Input,
    input  logic                  Rx_Read,
    output logic [DATA_WIDTH-1:0] Rx_Data,
    output logic                  Rx_Data_Available,
    output logic                  Rx_Parity_Error,
    output logic                  Rx_Frame_Error,
    output logic                  Rx_Overrun,
    output logic                  Rx_Busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic                  perr_q, perr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  avail_q, avail_d;
    logic                  rxperr_q, rxperr_d;
    logic                  ovr_q, ovr_d;
    logic                  ferr_q, ferr_d;

    logic                  w_busy;
    logic                  w_shift;
    logic                  w_par;
    logic                  w_stop_ok;
    logic                  w_stop_bad;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping Rx_Enable aborts from any state
    always_comb begin
        state_d = state_q;
        if (!Rx_Enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (!Rx_Serial_Input) state_d = S_DATA;
                S_DATA:   if (cnt_q == LAST_BIT) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Output / strobe decode
    always_comb begin
        w_busy     = (state_q != S_IDLE);
        w_shift    = (state_q == S_DATA)   && Rx_Enable;
        w_par      = (state_q == S_PARITY) && Rx_Enable;
        w_stop_ok  = (state_q == S_STOP)   && Rx_Enable &&  Rx_Serial_Input;
        w_stop_bad = (state_q == S_STOP)   && Rx_Enable && !Rx_Serial_Input;
    end

    always_comb begin
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        perr_d   = perr_q;
        data_d   = data_q;
        avail_d  = avail_q;
        rxperr_d = rxperr_q;
        ovr_d    = ovr_q;
        ferr_d   = 1'b0;

        if (state_q == S_IDLE) begin
            cnt_d  = '0;
            perr_d = 1'b0;
        end
        if (w_shift) begin
            sr_d  = {Rx_Serial_Input, sr_q[DATA_WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (w_par) begin
            perr_d = Rx_Serial_Input ^ (^sr_q);
        end

        // A read coinciding with a good stop frees the slot for the new word
        if (w_stop_ok) begin
            if (!avail_q || Rx_Read) begin
                data_d   = sr_q;
                avail_d  = 1'b1;
                rxperr_d = perr_q;
                if (Rx_Read) begin
                    ovr_d = 1'b0;
                end
            end else begin
                ovr_d = 1'b1;
            end
        end else if (Rx_Read && avail_q) begin
            avail_d  = 1'b0;
            rxperr_d = 1'b0;
            ovr_d    = 1'b0;
        end

        if (w_stop_bad) begin
            ferr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            sr_q     <= '0;
            perr_q   <= 1'b0;
            data_q   <= '0;
            avail_q  <= 1'b0;
            rxperr_q <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            perr_q   <= perr_d;
            data_q   <= data_d;
            avail_q  <= avail_d;
            rxperr_q <= rxperr_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
        end
    end

    assign Rx_Data           = data_q;
    assign Rx_Data_Available = avail_q;
    assign Rx_Parity_Error   = rxperr_q;
    assign Rx_Frame_Error    = ferr_q;
    assign Rx_Overrun        = ovr_q;
    assign Rx_Busy           = w_busy;

endmodule
`default_nettype wire
